slave_spi_rx: RTL and testbench

//  Node-side receiver downstream of master_spi in the interconnect network. Samples the

---
 rtl/spi_pkg.sv | 14 +
 rtl/slave_spi_rx_if.sv | 25 ++
 rtl/spi_sync.sv | 26 ++
 rtl/slave_spi_rx.sv | 194 +++++++++++++++++++
 tb/tb_slave_spi_rx.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master_spi / slave_spi_rx pair.
// Instruction width, bit-count width and the receiver FSM encoding.
package spi_pkg;

    localparam int INSTR_W = 32;
    localparam int CNT_W   = $clog2(INSTR_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/slave_spi_rx_if.sv
// Instruction handshake between the SPI receiver and the node core.
// The receiver drives through master; the consumer uses slave.
interface slave_spi_rx_if
    import spi_pkg::*;
#(
    parameter int WIDTH = INSTR_W
);

    logic [WIDTH-1:0] out_instr;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_instr,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_instr,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchroniser with a selectable reset level,
// so an idle line does not look like activity right after reset.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the raw input through the chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/slave_spi_rx.sv
// Node-side SPI instruction receiver: synchronise, deserialise one
// frame per cs_n window, hand it to the core through a holding register.
module slave_spi_rx
    import spi_pkg::*;
#(
    parameter int WIDTH       = INSTR_W,
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    slave_spi_rx_if.master        out_if,
    output logic                  overrun,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CW = $clog2(WIDTH + 1);

    logic sclk_s;
    logic csn_s;
    logic mosi_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn (
        .clk(clk), .rst_n(rst_n), .d_i(cs_n), .q_o(csn_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d_i(mosi), .q_o(mosi_s)
    );

    logic                   sclk_d1_q;
    logic                   csn_d1_q;
    logic                   rise_q;
    logic                   bit_q;
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   armed_q;
    logic                   armed_d;
    logic                   sclk_rise;
    logic                   csn_fall;

    assign sclk_rise = sclk_s & ~sclk_d1_q;
    // A cs_n fall only counts once a real high level has been seen,
    // so a frame already running at reset release is skipped.
    assign csn_fall  = csn_d1_q & ~csn_s & armed_q;
    assign armed_d   = armed_q | (prime_q[SYNC_STAGES-1] & csn_s);

    // Edge detection, sampled data bit and post-reset arming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d1_q <= 1'b0;
            csn_d1_q  <= 1'b1;
            rise_q    <= 1'b0;
            bit_q     <= 1'b0;
            prime_q   <= '0;
            armed_q   <= 1'b0;
        end else begin
            sclk_d1_q <= sclk_s;
            csn_d1_q  <= csn_s;
            rise_q    <= sclk_rise;
            bit_q     <= mosi_s;
            prime_q   <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            armed_q   <= armed_d;
        end
    end

    spi_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] shifted;
    logic             extra_q, extra_d;
    logic             load_q, load_d;
    logic             ferr_d;

    assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], bit_q}
                               : {bit_q, shreg_q[WIDTH-1:1]};

    // Frame FSM state, bit counter and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            extra_q <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            extra_q <= extra_d;
            load_q  <= load_d;
        end
    end

    // Frame FSM next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        extra_d = extra_q;
        load_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (csn_fall) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    shreg_d = '0;
                    extra_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (csn_s) begin
                    state_d = ST_IDLE;
                    ferr_d  = 1'b1;
                    cnt_d   = '0;
                    shreg_d = '0;
                end else if (rise_q) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_d == CW'(WIDTH)) begin
                        state_d = ST_DONE;
                        load_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (csn_s) begin
                    state_d = ST_IDLE;
                    ferr_d  = extra_q;
                end else if (rise_q) begin
                    extra_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic [WIDTH-1:0] instr_q, instr_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             err_q;
    logic             accept;

    assign accept = valid_q & out_if.out_ready;

    // Holding register: load, overrun on full, clear on handshake
    always_comb begin
        instr_d = instr_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (load_q) begin
            if (!valid_q || accept) begin
                instr_d = shreg_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    // Holding register and single-cycle flag outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            instr_q <= instr_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            err_q   <= ferr_d;
        end
    end

    assign out_if.out_instr = instr_q;
    assign out_if.out_valid = valid_q;
    assign overrun          = ovr_q;
    assign frame_err        = err_q;
    assign busy             = ~csn_s;

endmodule

// File: tb/tb_slave_spi_rx.sv
// Directed bench for slave_spi_rx: table of frames plus hand sequences
// for overrun, load-cycle handshake and mid-frame reset.
module tb_slave_spi_rx;
    import spi_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic cs_n  = 1'b1;
    logic mosi  = 1'b0;
    logic ovr1, err1, busy1;
    logic ovr2, err2, busy2;

    slave_spi_rx_if #(.WIDTH(32)) bus1 ();
    slave_spi_rx_if #(.WIDTH(32)) bus2 ();

    assign bus2.out_ready = 1'b1;

    slave_spi_rx #(.WIDTH(32), .SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .out_if(bus1.master), .overrun(ovr1), .frame_err(err1), .busy(busy1)
    );

    slave_spi_rx #(.WIDTH(32), .SYNC_STAGES(2), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .out_if(bus2.master), .overrun(ovr2), .frame_err(err2), .busy(busy2)
    );

    always #10 clk = ~clk;

    int          n_acc = 0;
    int          n_err = 0;
    int          n_ovr = 0;
    logic [31:0] last1 = '0;
    logic [31:0] last2 = '0;

    always @(negedge clk) begin
        if (bus1.out_valid && bus1.out_ready) begin
            n_acc <= n_acc + 1;
            last1 <= bus1.out_instr;
        end
        if (bus2.out_valid) last2 <= bus2.out_instr;
        if (err1) n_err <= n_err + 1;
        if (ovr1) n_ovr <= n_ovr + 1;
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mode 0: plain; 1: check load latency; 2: raise out_ready on load cycle
    task automatic shift_bits(input logic [63:0] data, input int nbits,
                              input int mode);
        for (int i = 0; i < nbits; i++) begin
            mosi = data[nbits-1-i];
            sclk = 1'b0;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            if (i == nbits - 1 && mode != 0) begin
                repeat (4) @(posedge clk);
                #1;
                if (mode == 1) chk("latency_pre", 32'(bus1.out_valid), 32'd0);
                else bus1.out_ready = 1'b1;
                @(posedge clk);
                #1;
                if (mode == 1) begin
                    chk("latency_post", 32'(bus1.out_valid), 32'd1);
                end else begin
                    chk("ldhs_valid", 32'(bus1.out_valid), 32'd1);
                    chk("ldhs_instr", bus1.out_instr, data[31:0]);
                    bus1.out_ready = 1'b0;
                end
                @(negedge clk);
            end else begin
                repeat (4) @(negedge clk);
            end
        end
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] data, input int nbits,
                              input int mode);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(data, nbits, mode);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic [63:0] data;
        int          nbits;
        int          mode;
        logic [31:0] e1;
        logic [31:0] e2;
        int          acc;
        int          err;
        int          ovr;
    } vec_t;

    vec_t vecs[5];
    int   a0, e0, o0;

    initial begin
        bus1.out_ready = 1'b0;
        // 0x00002710 streamed MSB first, received LSB first, is 0x08E40000
        vecs[0] = '{64'h0000_2710, 32, 1, 32'h0000_2710, 32'h08E4_0000, 1, 0, 0};
        vecs[1] = '{64'h1_ABCD, 17, 0, 32'h0000_2710, 32'h08E4_0000, 0, 1, 0};
        vecs[2] = '{64'h0000_FFFF, 32, 0, 32'h0000_FFFF, 32'hFFFF_0000, 1, 0, 0};
        vecs[3] = '{64'h1_4B4B_4B4B, 33, 0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1, 1, 0};
        vecs[4] = '{64'h1234_5678, 32, 0, 32'h1234_5678, 32'h1E6A_2C48, 1, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus1.out_valid), 32'd0);
        chk("rst_instr", bus1.out_instr, 32'd0);
        chk("rst_ovr", 32'(ovr1), 32'd0);
        chk("rst_err", 32'(err1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bus1.out_ready = 1'b1;

        for (int v = 0; v < 5; v++) begin
            a0 = n_acc; e0 = n_err; o0 = n_ovr;
            send_frame(vecs[v].data, vecs[v].nbits, vecs[v].mode);
            repeat (6) @(negedge clk);
            chk($sformatf("v%0d_instr", v), last1, vecs[v].e1);
            chk($sformatf("v%0d_lsb", v), last2, vecs[v].e2);
            chk($sformatf("v%0d_acc", v), 32'(n_acc - a0), 32'(vecs[v].acc));
            chk($sformatf("v%0d_err", v), 32'(n_err - e0), 32'(vecs[v].err));
            chk($sformatf("v%0d_ovr", v), 32'(n_ovr - o0), 32'(vecs[v].ovr));
        end

        // Holding register full: second frame is dropped
        bus1.out_ready = 1'b0;
        a0 = n_acc; o0 = n_ovr;
        send_frame(64'hDEAD_BEEF, 32, 0);
        send_frame(64'h1234_5678, 32, 0);
        repeat (6) @(negedge clk);
        chk("ovr_cnt", 32'(n_ovr - o0), 32'd1);
        chk("ovr_valid", 32'(bus1.out_valid), 32'd1);
        chk("ovr_instr", bus1.out_instr, 32'hDEAD_BEEF);
        chk("ovr_acc", 32'(n_acc - a0), 32'd0);

        // Handshake on the load cycle lets the new word in
        o0 = n_ovr;
        send_frame(64'h1234_5678, 32, 2);
        repeat (6) @(negedge clk);
        chk("hs_ovr", 32'(n_ovr - o0), 32'd0);
        chk("hs_valid", 32'(bus1.out_valid), 32'd1);
        chk("hs_instr", bus1.out_instr, 32'h1234_5678);
        chk("hs_taken", last1, 32'hDEAD_BEEF);
        bus1.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("drain_last", last1, 32'h1234_5678);
        chk("drain_valid", 32'(bus1.out_valid), 32'd0);

        // Reset in the middle of a frame
        a0 = n_acc; e0 = n_err;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(64'h3FF, 10, 0);
        chk("mid_busy", 32'(busy1), 32'd1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("mr_valid", 32'(bus1.out_valid), 32'd0);
        chk("mr_instr", bus1.out_instr, 32'd0);
        chk("mr_busy", 32'(busy1), 32'd0);
        chk("mr_ovr", 32'(ovr1), 32'd0);
        chk("mr_err", 32'(err1), 32'd0);
        rst_n = 1'b1;
        shift_bits(64'h3F_FFFF, 22, 0);
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("ign_acc", 32'(n_acc - a0), 32'd0);
        chk("ign_err", 32'(n_err - e0), 32'd0);
        chk("ign_instr", bus1.out_instr, 32'd0);
        send_frame(64'h1, 32, 0);
        repeat (6) @(negedge clk);
        chk("post_instr", last1, 32'h0000_0001);
        chk("post_lsb", last2, 32'h8000_0000);
        chk("post_err", 32'(n_err - e0), 32'd0);
        chk("post_acc", 32'(n_acc - a0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
